// File: rtl/fetch_pkg.sv
// fetch_pkg: FSM state type and shared constants for feature_fetch_ctrl
package fetch_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
    localparam int FIFO_DEPTH = 2;
    localparam int STALL_W    = 16;
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: two-entry FIFO whose output is driven straight from the head register
module fetch_fifo2 import fetch_pkg::*; #(
    parameter int WIDTH = 72
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d, slot;
    logic             push_ok, pop_ok;

    assign empty_o = cnt_q == 2'd0;
    assign full_o  = cnt_q == 2'(FIFO_DEPTH);
    assign data_o  = head_q;
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign slot    = cnt_q - {1'b0, pop_ok};

    // shift tail into head on pop; a push lands in the first free slot after the pop
    always_comb begin
        head_d = pop_ok ? tail_q : head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        if (push_ok && slot == 2'd0) head_d = data_i;
        if (push_ok && slot == 2'd1) tail_d = data_i;
    end

    // storage and occupancy registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/feature_fetch_ctrl.sv
// feature_fetch_ctrl: burst reader from a 1-cycle-latency memory into a ready/valid stream.
// Optional macro FETCH_STALL_CNT_EN adds stall_cnt_o, a saturating count of stalled cycles.
module feature_fetch_ctrl import fetch_pkg::*; #(
    parameter int MEMORY_WIDTH = 72,
    parameter int ADDRS_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic [ADDRS_WIDTH-1:0]  base_addrs_i,
    input  logic [ADDRS_WIDTH:0]    len_i,
    output logic [ADDRS_WIDTH-1:0]  addrs_mem_o,
    output logic                    rd_mem_ld_o,
    input  logic [MEMORY_WIDTH-1:0] mem_data_i,
    output logic [MEMORY_WIDTH-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    last_o,
    output logic                    busy_o,
    output logic                    done_o
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]      stall_cnt_o
`endif
);
    localparam logic [ADDRS_WIDTH:0] ONE = 1;

    state_e                 state_q, state_d;
    logic [ADDRS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRS_WIDTH:0]   rd_left_q, rd_left_d, xfer_left_q, xfer_left_d;
    logic                   inflight_q;
    logic                   fifo_full, fifo_empty, pop, issue;
    logic [1:0]             count;
    logic [2:0]             occ;

    fetch_fifo2 #(.WIDTH(MEMORY_WIDTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .data_i  (mem_data_i),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign valid_o     = ~fifo_empty;
    assign pop         = valid_o & ready_i;
    assign count       = {fifo_full, ~fifo_full & ~fifo_empty};
    assign occ         = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue       = state_q == ST_FETCH && rd_left_q != '0 && occ < 3'd2;
    assign rd_mem_ld_o = issue;
    assign addrs_mem_o = issue ? addr_q : '0;
    assign last_o      = valid_o && xfer_left_q == ONE;
    assign busy_o      = state_q != ST_IDLE;
    assign done_o      = state_q == ST_DONE;

    // burst sequencing: capture on start, count reads issued and words transferred
    always_comb begin
        state_d     = state_q;
        addr_d      = issue ? addr_q + ADDRS_WIDTH'(1) : addr_q;
        rd_left_d   = issue ? rd_left_q - ONE : rd_left_q;
        xfer_left_d = pop ? xfer_left_q - ONE : xfer_left_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                addr_d      = base_addrs_i;
                rd_left_d   = len_i;
                xfer_left_d = len_i;
                state_d     = len_i == '0 ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: if (issue && rd_left_q == ONE) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && xfer_left_q == ONE) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // control state; the in-flight flag marks a read whose data arrives next cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rd_left_q   <= '0;
            xfer_left_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_left_q   <= rd_left_d;
            xfer_left_q <= xfer_left_d;
            inflight_q  <= issue;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    // cleared by a new burst, saturates at all-ones
    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_IDLE && start_i) stall_d = '0;
        else if (valid_o && !ready_i && stall_q != '1) stall_d = stall_q + STALL_W'(1);
    end

    // stall counter register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) stall_q <= '0;
        else          stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_feature_fetch_ctrl.sv
// tb_feature_fetch_ctrl: randomized bursts checked against a queue-based stream model
module tb_feature_fetch_ctrl;
    localparam int MW = 72;
    localparam int AW = 8;

    logic          clk = 0, rst_n = 0, start_i = 0, ready_i = 1;
    logic [AW-1:0] base_i = '0, addrs_mem_o;
    logic [AW:0]   len_i = '0;
    logic          rd_mem_ld_o, valid_o, last_o, busy_o, done_o;
    logic [MW-1:0] mem_data_i, data_o;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]   stall_cnt_o;
`endif

    logic [MW-1:0] mem [256];
    int            tests = 0, fails = 0, cyc = 0, s_cyc = 0;
    logic [MW-1:0] obs_d [$];
    bit            obs_l [$];
    int            obs_cyc [$];
    logic [AW-1:0] rd_addr [$];
    int            rd_cyc [$];
    int            first_valid, done_cnt, done_cyc, busy_cnt, n_rd, n_xfer;
    int            viol_addr = 0, viol_stable = 0, viol_occ = 0;
    bit            prev_stall, clr_req = 0, clr_seen = 0;
    logic [MW-1:0] prev_d;
    logic          prev_l;

    feature_fetch_ctrl #(.MEMORY_WIDTH(MW), .ADDRS_WIDTH(AW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start_i),
        .base_addrs_i (base_i),
        .len_i        (len_i),
        .addrs_mem_o  (addrs_mem_o),
        .rd_mem_ld_o  (rd_mem_ld_o),
        .mem_data_i   (mem_data_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous memory: one-cycle read latency, zero when no read was issued
    always @(posedge clk) mem_data_i <= rd_mem_ld_o ? mem[addrs_mem_o] : '0;

    // mid-cycle observer: logs reads, transfers, done pulses and protocol violations
    always @(negedge clk) begin
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            obs_d.delete(); obs_l.delete(); obs_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
            first_valid = -1; done_cnt = 0; done_cyc = -1; busy_cnt = 0; n_rd = 0; n_xfer = 0;
            prev_stall = 0;
        end
        if (rd_mem_ld_o) begin rd_addr.push_back(addrs_mem_o); rd_cyc.push_back(cyc); end
        if (!rd_mem_ld_o && addrs_mem_o !== '0) viol_addr++;
        if (valid_o && ready_i) begin obs_d.push_back(data_o); obs_l.push_back(last_o); obs_cyc.push_back(cyc); end
        if (valid_o && first_valid < 0) first_valid = cyc;
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (busy_o) busy_cnt++;
        if (prev_stall && (!valid_o || data_o !== prev_d || last_o !== prev_l)) viol_stable++;
        if (n_rd - n_xfer > 2) viol_occ++;
        n_rd += int'(rd_mem_ld_o);
        n_xfer += int'(valid_o && ready_i);
        prev_stall = valid_o && !ready_i;
        prev_d = data_o;
        prev_l = last_o;
    end

    function automatic int bad_word(input logic [AW-1:0] b, input int l);
        if (obs_d.size() != l) return -2;
        for (int i = 0; i < l; i++)
            if (obs_d[i] !== mem[(int'(b) + i) % 256] || obs_l[i] != (i == l - 1)) return i;
        return -1;
    endfunction

    function automatic int bad_addr(input logic [AW-1:0] b, input int l);
        if (rd_addr.size() != l) return -2;
        for (int i = 0; i < l; i++)
            if (rd_addr[i] !== AW'((int'(b) + i) % 256)) return i;
        return -1;
    endfunction

    // mode 0: ready held high; 1: random ready; 2: six-cycle stall while the 3rd word is offered
    task automatic run_burst(input logic [AW-1:0] b, input int l, input int mode, input bit poke, output bit tmo);
        int stall_left = 0;
        bit stalled = 0;
        clr_req = ~clr_req;
        @(posedge clk); #1 start_i = 1; base_i = b; len_i = (AW+1)'(l); ready_i = 1;
        @(posedge clk); #1 s_cyc = cyc; start_i = 0; base_i = AW'($urandom); len_i = (AW+1)'($urandom);
        tmo = 1;
        for (int k = 0; k < 300; k++) begin
            if (done_cnt > 0) begin tmo = 0; break; end
            start_i = poke && k == 1;
            base_i = 8'h55;
            len_i = 9'd3;
            ready_i = mode == 1 ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mode == 2) begin
                if (!stalled && valid_o && obs_d.size() == 2) begin stalled = 1; stall_left = 6; end
                ready_i = stall_left == 0;
                if (stall_left > 0) stall_left--;
            end
            @(posedge clk); #1;
        end
        start_i = 0;
        ready_i = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({data_o, addrs_mem_o, valid_o, rd_mem_ld_o, last_o, busy_o, done_o} !== '0) begin
            fails++; $display("FAIL reset_outputs: got data=%0h addr=%0h v=%b rd=%b last=%b busy=%b done=%b, want all 0",
                              data_o, addrs_mem_o, valid_o, rd_mem_ld_o, last_o, busy_o, done_o); end
`ifdef FETCH_STALL_CNT_EN
        tests++; if (stall_cnt_o !== 16'd0) begin fails++; $display("FAIL reset_stall: got %0d want 0", stall_cnt_o); end
`endif
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if ({valid_o, rd_mem_ld_o, busy_o, done_o} !== 4'b0) begin
            fails++; $display("FAIL idle_outputs: got v=%b rd=%b busy=%b done=%b want 0", valid_o, rd_mem_ld_o, busy_o, done_o); end
    endtask

    task automatic test_basic();
        bit tmo, ok;
        int e;
        run_burst(8'h10, 4, 0, 0, tmo);
        tests++; if (tmo) begin fails++; $display("FAIL basic_timeout: got no done want done"); end
        e = bad_addr(8'h10, 4);
        tests++; if (e != -1) begin fails++; $display("FAIL basic_addr: got bad index %0d want -1", e); end
        ok = rd_cyc.size() == 4;
        foreach (rd_cyc[i]) if (rd_cyc[i] != s_cyc + i) ok = 0;
        tests++; if (!ok) begin fails++; $display("FAIL basic_rd_cycles: got first at +%0d want consecutive from +0",
                                                   rd_cyc.size() ? rd_cyc[0] - s_cyc : -1); end
        tests++; if (first_valid != s_cyc + 2) begin fails++; $display("FAIL basic_first_valid: got +%0d want +2", first_valid - s_cyc); end
        e = bad_word(8'h10, 4);
        tests++; if (e != -1) begin fails++; $display("FAIL basic_data: got bad index %0d want -1", e); end
        tests++; if (obs_cyc.size() != 4 || obs_cyc[3] != s_cyc + 5) begin
            fails++; $display("FAIL basic_throughput: got %0d transfers want 4 ending at +5", obs_cyc.size()); end
        tests++; if (done_cyc != s_cyc + 6 || done_cnt != 1) begin
            fails++; $display("FAIL basic_done: got +%0d x%0d want +6 x1", done_cyc - s_cyc, done_cnt); end
        tests++; if (busy_cnt != 7) begin fails++; $display("FAIL basic_busy: got %0d cycles want 7", busy_cnt); end
`ifdef FETCH_STALL_CNT_EN
        tests++; if (stall_cnt_o !== 16'd0) begin fails++; $display("FAIL basic_stall: got %0d want 0", stall_cnt_o); end
`endif
    endtask

    task automatic test_wrap();
        bit tmo;
        int e;
        run_burst(8'hFE, 4, 0, 0, tmo);
        tests++; if (tmo) begin fails++; $display("FAIL wrap_timeout: got no done want done"); end
        e = bad_addr(8'hFE, 4);
        tests++; if (e != -1) begin fails++; $display("FAIL wrap_addr: got bad index %0d want -1", e); end
        e = bad_word(8'hFE, 4);
        tests++; if (e != -1) begin fails++; $display("FAIL wrap_data: got bad index %0d want -1", e); end
    endtask

    task automatic test_empty();
        bit tmo;
        run_burst(8'h33, 0, 0, 0, tmo);
        tests++; if (tmo) begin fails++; $display("FAIL empty_timeout: got no done want done"); end
        tests++; if (rd_addr.size() != 0 || first_valid != -1) begin
            fails++; $display("FAIL empty_activity: got %0d reads first_valid %0d want 0 reads -1", rd_addr.size(), first_valid); end
        tests++; if (done_cyc != s_cyc || done_cnt != 1) begin
            fails++; $display("FAIL empty_done: got +%0d x%0d want +0 x1", done_cyc - s_cyc, done_cnt); end
    endtask

    task automatic test_stall();
        bit tmo;
        int e;
        run_burst(8'h60, 8, 2, 0, tmo);
        tests++; if (tmo) begin fails++; $display("FAIL stall_timeout: got no done want done"); end
        e = bad_word(8'h60, 8);
        tests++; if (e != -1) begin fails++; $display("FAIL stall_data: got bad index %0d want -1", e); end
        tests++; if (obs_cyc.size() != 8 || obs_cyc[7] - obs_cyc[0] != 13) begin
            fails++; $display("FAIL stall_span: got %0d transfers want 8 over 14 cycles", obs_cyc.size()); end
        tests++; if (viol_stable != 0 || viol_occ != 0) begin
            fails++; $display("FAIL stall_hold: got unstable=%0d overfill=%0d want 0 0", viol_stable, viol_occ); end
`ifdef FETCH_STALL_CNT_EN
        tests++; if (stall_cnt_o !== 16'd6) begin fails++; $display("FAIL stall_cnt: got %0d want 6", stall_cnt_o); end
`endif
    endtask

    task automatic test_start_ignored();
        bit tmo;
        int e;
        run_burst(8'h40, 8, 0, 1, tmo);
        tests++; if (tmo) begin fails++; $display("FAIL ign_timeout: got no done want done"); end
        e = bad_addr(8'h40, 8);
        tests++; if (e != -1) begin fails++; $display("FAIL ign_addr: got bad index %0d want -1", e); end
        e = bad_word(8'h40, 8);
        tests++; if (e != -1) begin fails++; $display("FAIL ign_data: got bad index %0d want -1", e); end
        tests++; if (done_cnt != 1 || busy_o !== 1'b0) begin
            fails++; $display("FAIL ign_done: got done x%0d busy=%b want x1 busy=0", done_cnt, busy_o); end
`ifdef FETCH_STALL_CNT_EN
        tests++; if (stall_cnt_o !== 16'd0) begin fails++; $display("FAIL ign_stall_clear: got %0d want 0", stall_cnt_o); end
`endif
    endtask

    task automatic test_reset_mid();
        bit tmo, hit = 0;
        int e;
        clr_req = ~clr_req;
        @(posedge clk); #1 start_i = 1; base_i = 8'h20; len_i = 9'd8; ready_i = 1;
        @(posedge clk); #1 start_i = 0;
        for (int k = 0; k < 50 && !hit; k++) begin
            if (valid_o && obs_d.size() == 2) hit = 1;
            else begin @(posedge clk); #1; end
        end
        tests++; if (!hit) begin fails++; $display("FAIL rstmid_reach: got %0d words want 3rd word offered", obs_d.size()); end
        #2 rst_n = 0;
        #1;
        tests++; if ({data_o, addrs_mem_o, valid_o, rd_mem_ld_o, last_o, busy_o, done_o} !== '0) begin
            fails++; $display("FAIL rstmid_outputs: got data=%0h addr=%0h v=%b rd=%b last=%b busy=%b done=%b, want all 0",
                              data_o, addrs_mem_o, valid_o, rd_mem_ld_o, last_o, busy_o, done_o); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        tests++; if (done_cnt != 0 || valid_o !== 1'b0) begin
            fails++; $display("FAIL rstmid_abort: got done x%0d valid=%b want x0 valid=0", done_cnt, valid_o); end
        run_burst(8'h80, 5, 1, 0, tmo);
        tests++; if (tmo) begin fails++; $display("FAIL rstmid_timeout: got no done want done"); end
        e = bad_word(8'h80, 5);
        tests++; if (e != -1 || done_cnt != 1) begin
            fails++; $display("FAIL rstmid_rerun: got bad index %0d done x%0d want -1 x1", e, done_cnt); end
    endtask

    task automatic test_random();
        bit tmo;
        int e, a, l;
        logic [AW-1:0] b;
        for (int n = 0; n < 6; n++) begin
            b = AW'($urandom);
            l = $urandom_range(1, 12);
            run_burst(b, l, 1, 0, tmo);
            e = bad_word(b, l);
            a = bad_addr(b, l);
            tests++; if (tmo || e != -1 || a != -1 || done_cnt != 1) begin
                fails++; $display("FAIL rand_%0d: got tmo=%b word=%0d addr=%0d done x%0d (base %0h len %0d) want 0 -1 -1 x1",
                                  n, tmo, e, a, done_cnt, b, l); end
        end
    endtask

    task automatic test_invariants();
        tests++; if (viol_addr != 0) begin fails++; $display("FAIL addr_idle_zero: got %0d violations want 0", viol_addr); end
        tests++; if (viol_stable != 0) begin fails++; $display("FAIL hold_stable: got %0d violations want 0", viol_stable); end
        tests++; if (viol_occ != 0) begin fails++; $display("FAIL occupancy: got %0d violations want 0", viol_occ); end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = MW'({$urandom, $urandom, $urandom});
        test_reset();
        test_basic();
        test_wrap();
        test_empty();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
